// File: rtl/sm_regdump.sv
// sm_regdump: debug register-file scanner.
// Walks regAddr from FIRST_REG to LAST_REG. Each register is captured from the
// core's combinational regData and emitted as an {address, data} beat on a
// valid/ready stream. A scan starts on a start pulse or on an optional
// periodic trigger.
module sm_regdump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int PERIOD    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SEND  = 2'd2
    } scanState_t;

    localparam logic [4:0]  FIRST_ADDR  = 5'(FIRST_REG);
    localparam logic [4:0]  LAST_ADDR   = 5'(LAST_REG);
    // PERIOD == 0 means the periodic trigger is disabled entirely. The wrap
    // value is clamped so it never underflows in that case.
    localparam bit          PERIODIC_EN = (PERIOD > 0);
    localparam logic [31:0] PERIOD_LAST = (PERIOD > 0) ? 32'(PERIOD - 1) : 32'd0;

    scanState_t  scanState;
    logic [31:0] periodCount;
    logic        periodTrig;

    // The periodic trigger is a one-cycle strobe on the wrap cycle. It is seen
    // by the FSM on the same edge that wraps the counter.
    assign periodTrig = PERIODIC_EN && (periodCount == PERIOD_LAST);

    // Free-running period counter. It runs in every state, so triggers that
    // land mid-scan are simply lost rather than deferred.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            periodCount <= 32'd0;
        end else if (periodTrig) begin
            periodCount <= 32'd0;
        end else begin
            periodCount <= periodCount + 32'd1;
        end
    end

    // Scan FSM. Every output is registered here.
    // SETUP gives regData a full cycle to settle before it is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scanState <= IDLE;
            regAddr   <= 5'd0;
            out_valid <= 1'b0;
            out_addr  <= 5'd0;
            out_data  <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (scanState)
                IDLE: begin
                    // start and periodTrig together still start only one scan.
                    if (start || periodTrig) begin
                        regAddr   <= FIRST_ADDR;
                        busy      <= 1'b1;
                        scanState <= SETUP;
                    end
                end
                SETUP: begin
                    out_data  <= regData;
                    out_addr  <= regAddr;
                    out_valid <= 1'b1;
                    scanState <= SEND;
                end
                SEND: begin
                    // Everything holds while the sink stalls. regData is
                    // ignored here, so the captured value cannot change.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (regAddr == LAST_ADDR) begin
                            // Park on index 0 so the PC stays visible.
                            regAddr   <= 5'd0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            scanState <= IDLE;
                        end else begin
                            regAddr   <= regAddr + 5'd1;
                            scanState <= SETUP;
                        end
                    end
                end
                default: begin
                    scanState <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_regdump.sv
// tb_sm_regdump: directed and randomized checks of sm_regdump against a
// register-file model. The expected beats and timing are derived from the scan
// rules: N beats, 2 cycles per beat, plus one cycle for each stalled cycle.
module tb_sm_regdump;

    localparam int N = 32;   // default FIRST_REG = 0 .. LAST_REG = 31

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (defaults)
    logic        rst_n, start, out_ready;
    logic [4:0]  regAddr, out_addr;
    logic [31:0] regData, out_data;
    logic        out_valid, busy, done;

    // Periodic DUT
    logic        rst2_n, start2, ready2;
    logic [4:0]  regAddr2, oaddr2;
    logic [31:0] regData2, odata2;
    logic        ovalid2, busy2, done2;

    // CPU model: PC at index 0, register file elsewhere, read combinationally
    logic [31:0] pc;
    logic [31:0] rf [32];
    assign regData  = (regAddr  == 5'd0) ? pc : rf[regAddr];
    assign regData2 = (regAddr2 == 5'd0) ? pc : rf[regAddr2];

    sm_regdump dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .regAddr(regAddr), .regData(regData),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    sm_regdump #(.FIRST_REG(2), .LAST_REG(3), .PERIOD(100)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start2),
        .regAddr(regAddr2), .regData(regData2),
        .out_valid(ovalid2), .out_ready(ready2),
        .out_addr(oaddr2), .out_data(odata2),
        .busy(busy2), .done(done2)
    );

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refVal(input int idx);
        return (idx == 0) ? pc : rf[idx];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chkResetValues(input string tag);
        chk({tag, "_regAddr"},   32'(regAddr),   32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_addr"},  32'(out_addr),  32'd0);
        chk({tag, "_out_data"},  out_data,       32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // Pulse (or raise) start at a negedge. Return at the negedge after E0.
    task automatic startScan(input bit keepHigh);
        start = 1'b1;
        step();
        if (!keepHigh) start = 1'b0;
        chk("e0_busy",      32'(busy),      32'd1);
        chk("e0_regAddr",   32'(regAddr),   32'd0);
        chk("e0_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Follow one scan from the negedge after E0 to the negedge where done
    // shows up. Each valid beat is checked against the model values captured
    // at scan start.
    task automatic collectScan(input int stallBeat, input int stallLen, input bit randomReady,
                               input bit poke99, input int startBeat, input int resetBeat);
        logic [31:0] expData [N];
        int  j = 0, beat = 0, stalls = 0, stallCount = 0;
        bit  gotDone = 1'b0, pulseActive = 1'b0;
        for (int i = 0; i < N; i++) expData[i] = refVal(i);
        out_ready = 1'b1;
        while (j < 3000) begin
            step();
            j++;
            if (pulseActive) begin
                start = 1'b0;
                pulseActive = 1'b0;
            end
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            chk("scan_busy", 32'(busy), 32'd1);
            if (out_valid) begin
                chk($sformatf("beat%0d_addr", beat), 32'(out_addr), 32'(beat));
                chk($sformatf("beat%0d_data", beat), out_data, expData[beat]);
                chk($sformatf("beat%0d_regAddr", beat), 32'(regAddr), 32'(beat));
                if (beat == resetBeat) begin
                    rst_n = 1'b0;
                    step();
                    chkResetValues("midreset");
                    rst_n = 1'b1;
                    step();
                    chkResetValues("postreset");
                    return;
                end
                if (beat == startBeat && !start) begin
                    start = 1'b1;
                    pulseActive = 1'b1;
                end
                if (beat == stallBeat && stallCount < stallLen) begin
                    if (poke99 && stallCount == 0) rf[beat] = 32'd99;
                    out_ready = 1'b0;
                    stallCount++;
                    stalls++;
                end else if (randomReady && $urandom_range(0, 2) == 0) begin
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    beat++;
                end
            end else begin
                out_ready = ($urandom_range(0, 1) == 1);
            end
        end
        chk("scan_got_done", 32'(gotDone), 32'd1);
        chk("scan_done_edge", 32'(j), 32'(2 * N + stalls));
        chk("scan_beats", 32'(beat), 32'(N));
        chk("scan_done_busy", 32'(busy), 32'd0);
        chk("scan_done_valid", 32'(out_valid), 32'd0);
        chk("scan_done_regAddr", 32'(regAddr), 32'd0);
        out_ready = 1'b1;
    endtask

    task automatic finishIdle();
        step();
        chk("idle_done_low", 32'(done), 32'd0);
        chk("idle_busy_low", 32'(busy), 32'd0);
    endtask

    int rises[$];
    int expRises[5] = '{99, 199, 299, 399, 599};

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        rst2_n = 1'b0; start2 = 1'b0; ready2 = 1'b1;
        pc = 32'd5;
        for (int i = 0; i < 32; i++) rf[i] = 32'(16 * i);
        @(negedge clk);
        step(); step();
        chkResetValues("reset");
        rst_n = 1'b1;
        step();
        chkResetValues("idle");

        // Full scan, rf[i] = 16*i, PC = 5
        startScan(1'b0);
        collectScan(-1, 0, 1'b0, 1'b0, -1, -1);
        finishIdle();

        // Back-pressure: 10 stalled cycles on beat 3
        startScan(1'b0);
        collectScan(3, 10, 1'b0, 1'b0, -1, -1);
        finishIdle();

        // Capture hold: rf[4] changes to 99 after capture, beat stays 64
        startScan(1'b0);
        collectScan(4, 6, 1'b0, 1'b1, -1, -1);
        finishIdle();
        rf[4] = 32'd64;

        // Start pulse mid-scan is ignored
        startScan(1'b0);
        collectScan(-1, 0, 1'b0, 1'b0, 7, -1);
        finishIdle();
        step();
        chk("no_extra_scan", 32'(busy), 32'd0);

        // Reset during beat 5, then a clean restart
        startScan(1'b0);
        collectScan(-1, 0, 1'b0, 1'b0, -1, 5);
        startScan(1'b0);
        collectScan(-1, 0, 1'b0, 1'b0, -1, -1);
        finishIdle();

        // start held high: one IDLE cycle (the done cycle) between scans
        startScan(1'b1);
        collectScan(-1, 0, 1'b0, 1'b0, -1, -1);
        step();
        chk("held_rescan_busy", 32'(busy), 32'd1);
        chk("held_rescan_done", 32'(done), 32'd0);
        chk("held_rescan_valid", 32'(out_valid), 32'd0);
        start = 1'b0;
        collectScan(-1, 0, 1'b0, 1'b0, -1, -1);
        finishIdle();

        // Randomized contents and random back-pressure
        for (int r = 0; r < 3; r++) begin
            pc = $urandom();
            for (int i = 0; i < 32; i++) rf[i] = $urandom();
            startScan(1'b0);
            collectScan(-1, 0, 1'b1, 1'b0, -1, -1);
            finishIdle();
        end

        // Periodic mode. P_k is the k-th edge after reset release, and
        // triggers fall on P99, P199, ... Sink stalls for edges P400..P549,
        // so the P499 trigger hits a busy scanner and is dropped.
        begin
            int beats2 = 0, dones2 = 0;
            bit prevBusy = 1'b0;
            logic [4:0] expAddr;
            rf[2] = $urandom();
            rf[3] = $urandom();
            rst2_n = 1'b1;
            for (int k = 0; k < 699; k++) begin
                step();
                if (busy2 && !prevBusy) rises.push_back(k);
                prevBusy = busy2;
                if (done2) dones2++;
                ready2 = !(k >= 399 && k <= 548);
                if (ovalid2 && ready2) begin
                    expAddr = 5'(2 + (beats2 % 2));
                    chk("per_beat_addr", 32'(oaddr2), 32'(expAddr));
                    chk("per_beat_data", odata2, rf[expAddr]);
                    beats2++;
                end
            end
            chk("per_scan_count", 32'(rises.size()), 32'd5);
            for (int i = 0; i < 5; i++)
                chk($sformatf("per_rise%0d", i),
                    (i < rises.size()) ? 32'(rises[i]) : 32'hFFFF_FFFF, 32'(expRises[i]));
            chk("per_beats", 32'(beats2), 32'd10);
            chk("per_dones", 32'(dones2), 32'd5);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/sm_regdump.md
# sm_regdump

Debug register-file scanner that sits directly downstream of the CPU core's debug read port. It drives the core's `regAddr`, samples the combinational `regData`, and emits each register as an {address, data} beat on a valid/ready stream toward a display, UART or trace sink. Scans start on a `start` pulse or on an optional periodic trigger. The CPU keeps running during a scan, so a scan is a sequence of individual reads, not an atomic snapshot.

## Interface
- `FIRST_REG`, default 0: first register index scanned; index 0 returns the PC.
- `LAST_REG`, default 31: last register index scanned. Must satisfy FIRST_REG ≤ LAST_REG ≤ 31.
- `PERIOD`, default 0: auto-trigger interval in clock cycles. 0 disables auto-triggering.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `start`  in  1  scan request. Sampled on each rising edge; honoured only in IDLE.
- `regAddr`  out  5  debug read address to the CPU core.
- `regData`  in  32  debug read data from the CPU core. Combinational from `regAddr`.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  sink accepts the beat.
- `out_addr`  out  5  register index of the current beat.
- `out_data`  out  32  captured register value.
- `busy`  out  1  high while a scan is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when the last beat is accepted.

## Operation
- State machine with states IDLE, SETUP and SEND. All outputs are registered.
- **IDLE:** `regAddr` = 0, so the PC stays visible.
  - On a trigger (`start` or periodic): `regAddr` ← FIRST_REG, `busy` ← 1, go to SETUP.
- **SETUP** (always exactly one cycle): `regData` settles during this cycle. At the edge:
  - `out_data` ← `regData`
  - `out_addr` ← `regAddr`
  - `out_valid` ← 1
  - go to SEND
- **SEND:** on `out_valid & out_ready`:
  - `out_valid` ← 0.
  - If `regAddr` == LAST_REG: `regAddr` ← 0, `busy` ← 0, `done` ← 1, go to IDLE.
  - Otherwise: `regAddr` ← `regAddr` + 1, go to SETUP.
- While `out_ready` is low, `out_valid`, `out_addr`, `out_data` and `regAddr` hold. Changes on `regData` are ignored after capture.
- **Periodic trigger:**
  - 32-bit counter, cleared by reset, increments every cycle regardless of state.
  - When it equals PERIOD−1 it wraps to 0 and raises an internal trigger for one cycle.
  - A trigger that arrives outside IDLE is dropped, not queued.
  - `start` and the periodic trigger in the same cycle produce a single scan.
- `start` asserted while busy is ignored. `start` held high continuously gives back-to-back scans with one IDLE cycle between them.
- `regAddr` arithmetic is 5-bit. It never wraps because LAST_REG ≤ 31 ends the scan first.

## Timing
- **Reset values:**
  - `regAddr` = 0, `out_valid` = 0, `out_addr` = 0, `out_data` = 0, `busy` = 0, `done` = 0
  - state IDLE, period counter = 0
- **Reset mid-scan:** the scan is abandoned. Values above apply on the next cycle; no `done` pulse.
- Edge numbering: E0 is the edge that samples `start`.
  - After E0: `busy` = 1, `regAddr` = FIRST_REG.
  - Beat k (0-based) has `out_valid` high after edge E(2k+1) when `out_ready` is tied high.
- Throughput with `out_ready` high: one beat per 2 cycles. Each cycle of `out_ready` low adds one cycle.
- For N = LAST_REG−FIRST_REG+1 registers with no back-pressure:
  - last beat accepted at E(2N)
  - `done` high for the cycle after E(2N)
  - `busy` low after E(2N)
- Earliest next scan: a `start` sampled at E(2N+1).

## Test plan
- **Full scan:** preload rf[i] = 16·i, PC = 5, `out_ready` = 1, one-cycle `start`, defaults. Required response:
  - 32 beats, `out_addr` 0..31
  - `out_data` = 5 for index 0, 16·i for index i ≥ 1
  - `done` pulse after E64, `busy` low after E64
- **Back-pressure:** drop `out_ready` for 10 cycles while beat 3 is valid. `out_valid`, `out_addr` = 3, `out_data` = 48 and `regAddr` = 3 stay stable. The scan completes 10 cycles late.
- **Start while busy:** pulse `start` mid-scan → ignored, exactly 32 beats. Hold `start` high for 2 scans → one IDLE cycle between the `done` pulse and the next SETUP.
- **Reset mid-scan:** assert `rst_n` low during beat 5. Next cycle all outputs are at reset values with no `done`. A later `start` restarts at `out_addr` = FIRST_REG.
- **Periodic mode:** PERIOD = 100, FIRST_REG = 2, LAST_REG = 3, `out_ready` = 1. A scan starts every 100 cycles with 2 beats per scan. Holding `out_ready` low for 150 cycles drops the next trigger; there is no queued second scan.
- **Capture hold:** change rf[4] from 64 to 99 while beat 4 waits with `out_ready` low. `out_data` stays 64.
